// File: rtl/dpe_pkg.sv
`default_nettype none
// ==== dpe_pkg: state type, lane-select width and round/saturate helper for dot_product_engine | rev 1.0 ====
package dpe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int MAX_ACC_W  = 128;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                         sat;
    logic signed [MAX_DATA_W-1:0] val;
  } sat_res_t;

  function automatic int sel_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // acc arrives sign-extended to MAX_ACC_W; caller keeps the low data_w bits of val
  function automatic sat_res_t round_sat(input logic signed [MAX_ACC_W-1:0] acc,
                                         input int data_w, input int frac_w);
    logic signed [MAX_ACC_W-1:0] rnd;
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    sat_res_t res;
    rnd = '0;
    if (frac_w > 0) rnd = MAX_ACC_W'(1) << (frac_w - 1);
    r  = (acc + rnd) >>> frac_w;
    hi = (MAX_ACC_W'(1) << (data_w - 1)) - MAX_ACC_W'(1);
    lo = ~hi;
    res.sat = 1'b1;
    if (r > hi) begin
      res.val = hi[MAX_DATA_W-1:0];
    end else if (r < lo) begin
      res.val = lo[MAX_DATA_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = r[MAX_DATA_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_product_engine_if.sv
`default_nettype none
// ==== dot_product_engine_if: load, command and result channels of the dot-product engine | rev 1.0 ====
interface dot_product_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LANES  = 4
) ();
  import dpe_pkg::*;

  localparam int SEL_W = sel_w(LANES);

  logic                      ld_valid;
  logic                      ld_ready;
  logic [SEL_W-1:0]          ld_sel;
  logic [ADDR_W-1:0]         ld_addr;
  logic [DATA_W-1:0]         ld_data;
  logic                      start;
  logic [ADDR_W-1:0]         len;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          out_sat;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start, len, out_ready,
    input  ld_ready, busy, out_valid, out_data, out_sat
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start, len, out_ready,
    output ld_ready, busy, out_valid, out_data, out_sat
  );

endinterface
`default_nettype wire

// File: rtl/dpe_lane.sv
`default_nettype none
// ==== dpe_lane: one column buffer, multiplier, accumulator and saturated result register | rev 1.0 ====
module dpe_lane
  import dpe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 2*DATA_W+ADDR_W,
  parameter int FRAC_W = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] row_data,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     res_load,
  output logic [DATA_W-1:0]        result,
  output logic                     sat
);

  logic [DATA_W-1:0]          col_mem [2**ADDR_W];
  logic signed [DATA_W-1:0]   col_q;
  logic [2*DATA_W-1:0]        prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  sat_res_t                   res;
  logic                       unused_res_hi;

  // buffer has no reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (wr_en) col_mem[wr_addr] <= wr_data;
    col_q <= col_mem[rd_addr];
  end

  assign prod = {{DATA_W{row_data[DATA_W-1]}}, row_data} *
                {{DATA_W{col_q[DATA_W-1]}}, col_q};
  assign acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // result is taken from acc_next so the final product lands in the same edge
  assign res = round_sat({{(MAX_ACC_W-ACC_W){acc_next[ACC_W-1]}}, acc_next}, DATA_W, FRAC_W);
  assign unused_res_hi = ^res.val[MAX_DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc_next;
      if (res_load) begin
        result <= res.val[DATA_W-1:0];
        sat    <= res.sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_product_engine.sv
`default_nettype none
// ==== dot_product_engine: LANES-wide signed dot product with row buffer, sequencer and output handshake | rev 1.0 ====
module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LANES  = 4,
  parameter int FRAC_W = 0,
  parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_engine_if.slave  bus
);

  localparam int SEL_W = sel_w(LANES);

  state_t                    state;
  logic [ADDR_W-1:0]         rd_addr;
  logic [ADDR_W-1:0]         len_q;
  logic                      data_vld;
  logic [DATA_W-1:0]         row_mem [2**ADDR_W];
  logic signed [DATA_W-1:0]  row_q;
  logic                      wr_ok;
  logic                      start_ok;
  logic [LANES*DATA_W-1:0]   res_bus;
  logic [LANES-1:0]          sat_bus;

  assign wr_ok    = bus.ld_valid & bus.ld_ready;
  assign start_ok = bus.start & (state == IDLE);

  always_ff @(posedge clk) begin
    if (wr_ok && bus.ld_sel == '0) row_mem[bus.ld_addr] <= bus.ld_data;
    row_q <= row_mem[rd_addr];
  end

  // data_vld trails RUN by one cycle to match the buffer read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      len_q         <= '0;
      data_vld      <= 1'b0;
      bus.ld_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      data_vld <= (state == RUN);
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RUN;
            len_q        <= bus.len;
            rd_addr      <= '0;
            bus.ld_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr == len_q) state <= DRAIN;
          else                  rd_addr <= rd_addr + ADDR_W'(1);
        end
        DRAIN: begin
          state         <= OUT;
          bus.out_valid <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ld_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      dpe_lane #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok && (bus.ld_sel == SEL_W'(k+1))),
        .wr_addr  (bus.ld_addr),
        .wr_data  (bus.ld_data),
        .rd_addr  (rd_addr),
        .row_data (row_q),
        .clr      (start_ok),
        .acc_en   (data_vld),
        .res_load (state == DRAIN),
        .result   (res_bus[k*DATA_W +: DATA_W]),
        .sat      (sat_bus[k])
      );
    end
  endgenerate

  assign bus.out_data = res_bus;
  assign bus.out_sat  = sat_bus;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// ==== tb_dot_product_engine: scoreboard bench for a 32-bit engine and an 8-bit FRAC_W=2 engine | rev 1.0 ====
module tb_dot_product_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_product_engine_if #(.DATA_W(32), .ADDR_W(4), .LANES(4)) bus ();
  dot_product_engine_if #(.DATA_W(8),  .ADDR_W(4), .LANES(2)) bus8 ();

  dot_product_engine #(.DATA_W(32), .ADDR_W(4), .LANES(4), .FRAC_W(0)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  dot_product_engine #(.DATA_W(8), .ADDR_W(4), .LANES(2), .FRAC_W(2)) u_dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  typedef struct {
    logic [127:0] d;
    logic [3:0]   s;
    int           c;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  bit   seen0 = 1'b0;
  bit   seen8 = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [127:0] pk4(int a, int b, int c, int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  // Monitors: compare every cycle a result is presented, pop on handshake
  always @(negedge clk) begin
    if (!rst) seen0 = 1'b0;
    else if (bus.out_valid) begin
      if (q0.size() == 0) chk("unexpected_valid", bus.out_valid, 0);
      else begin
        if (!seen0) begin
          chk("latency", cyc, q0[0].c);
          seen0 = 1'b1;
        end
        chk("out_data", bus.out_data, q0[0].d);
        chk("out_sat", bus.out_sat, q0[0].s);
        if (bus.out_ready) begin
          void'(q0.pop_front());
          seen0 = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) seen8 = 1'b0;
    else if (bus8.out_valid) begin
      if (q8.size() == 0) chk("unexpected_valid8", bus8.out_valid, 0);
      else begin
        if (!seen8) begin
          chk("latency8", cyc, q8[0].c);
          seen8 = 1'b1;
        end
        chk("out_data8", bus8.out_data, q8[0].d);
        chk("out_sat8", bus8.out_sat, q8[0].s);
        if (bus8.out_ready) begin
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [2:0] sel, input logic [3:0] addr, input logic [31:0] data);
    bus.ld_valid = 1'b1; bus.ld_sel = sel; bus.ld_addr = addr; bus.ld_data = data;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic fill4(input logic [2:0] sel, input int a, input int b, input int c, input int d);
    wr(sel, 4'd0, a); wr(sel, 4'd1, b); wr(sel, 4'd2, c); wr(sel, 4'd3, d);
  endtask

  task automatic run(input logic [3:0] ln, input logic [127:0] d, input logic [3:0] s);
    exp_t e;
    e.d = d; e.s = s; e.c = cyc + int'(ln) + 3;
    q0.push_back(e);
    bus.start = 1'b1; bus.len = ln;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wr8(input logic [1:0] sel, input logic [3:0] addr, input logic [7:0] data);
    bus8.ld_valid = 1'b1; bus8.ld_sel = sel; bus8.ld_addr = addr; bus8.ld_data = data;
    @(posedge clk); #1;
    bus8.ld_valid = 1'b0;
  endtask

  task automatic run8(input logic [3:0] ln, input logic [15:0] d, input logic [1:0] s);
    exp_t e;
    e.d = 128'(d); e.s = 4'(s); e.c = cyc + int'(ln) + 3;
    q8.push_back(e);
    bus8.start = 1'b1; bus8.len = ln;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus8.busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", bus.busy | bus8.busy, 0);
    chk("sb_empty", q0.size() + q8.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", bus.out_valid, 1);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ld_ready"},  bus.ld_ready, 1);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data, 0);
    chk({tag, "_out_sat"},   bus.out_sat, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.start = 0; bus.len = 0; bus.out_ready = 1;
    bus8.ld_valid = 0; bus8.ld_sel = 0; bus8.ld_addr = 0; bus8.ld_data = 0;
    bus8.start = 0; bus8.len = 0; bus8.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    // basic dot product, then a shorter length over the same buffers
    fill4(3'd0, 1, 2, 3, 4);
    fill4(3'd1, 1, 1, 1, 1);
    fill4(3'd2, -1, 0, 0, 2);
    fill4(3'd3, 0, 0, 0, 0);
    fill4(3'd4, 5, 5, 5, 5);
    run(4'd3, pk4(10, 7, 0, 50), 4'b0000);
    wait_idle();
    wr(3'd5, 4'd0, 32'd1000);
    wr(3'd7, 4'd1, 32'd1000);
    run(4'd1, pk4(3, -1, 0, 15), 4'b0000);
    wait_idle();

    // backpressure with ignored start/write while busy
    bus.out_ready = 1'b0;
    run(4'd3, pk4(10, 7, 0, 50), 4'b0000);
    bus.start = 1'b1; bus.len = 4'd0;
    bus.ld_valid = 1'b1; bus.ld_sel = 3'd1; bus.ld_addr = 4'd0; bus.ld_data = 32'd77;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.ld_valid = 1'b0;
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_ld_ready", bus.ld_ready, 0);
    chk("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ld_ready", bus.ld_ready, 1);
    chk("bp_busy", bus.busy, 0);
    chk("bp_valid_low", bus.out_valid, 0);
    wait_idle();
    run(4'd3, pk4(10, 7, 0, 50), 4'b0000);
    wait_idle();

    // positive and negative saturation at 32 bits
    fill4(3'd0, 32'h7fffffff, 32'h7fffffff, 0, 0);
    fill4(3'd1, 32'h7fffffff, 32'h7fffffff, 0, 0);
    fill4(3'd2, 32'h80000000, 32'h80000000, 0, 0);
    fill4(3'd3, 1, -1, 0, 0);
    fill4(3'd4, -1, 0, 0, 0);
    run(4'd1, pk4(32'h7fffffff, 32'h80000000, 0, 32'h80000001), 4'b0011);
    wait_idle();

    // maximum length
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 16; a++)
        wr(3'(s), 4'(a), 32'd1);
    run(4'd15, pk4(16, 16, 16, 16), 4'b0000);
    wait_idle();

    // reset two cycles into a long run, then rerun on retained buffers
    run(4'd15, pk4(16, 16, 16, 16), 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    #1;
    chk_reset("midrun");
    @(posedge clk); #1;
    rst = 1'b1;
    run(4'd15, pk4(16, 16, 16, 16), 4'b0000);
    wait_idle();

    // 8-bit engine with FRAC_W=2: rounding and saturation
    wr8(2'd0, 4'd0, 8'd3); wr8(2'd1, 4'd0, 8'd2); wr8(2'd2, 4'd0, 8'hff);
    run8(4'd0, {8'hff, 8'h02}, 2'b00);
    wait_idle();
    wr8(2'd0, 4'd0, 8'd1); wr8(2'd1, 4'd0, 8'd2); wr8(2'd2, 4'd0, 8'hfe);
    run8(4'd0, {8'h00, 8'h01}, 2'b00);
    wait_idle();
    wr8(2'd0, 4'd0, 8'd127); wr8(2'd0, 4'd1, 8'd127);
    wr8(2'd1, 4'd0, 8'd127); wr8(2'd1, 4'd1, 8'd127);
    wr8(2'd2, 4'd0, 8'h80);  wr8(2'd2, 4'd1, 8'd127);
    run8(4'd1, {8'he0, 8'h7f}, 2'b01);
    wait_idle();
    wr8(2'd0, 4'd0, 8'h80); wr8(2'd0, 4'd1, 8'h80);
    wr8(2'd2, 4'd0, 8'hfe); wr8(2'd2, 4'd1, 8'h00);
    run8(4'd1, {8'h40, 8'h80}, 2'b01);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
